wb_arbiter: RTL
===============

# wb_arbiter

Round-robin Wishbone arbiter that lets several bus masters (MCU core, DMA engine, debug bridge) share the single-master peripheral interconnect. It sits between the masters and the interconnect's controller-side port. It grants the bus for a whole `cyc` cycle, routes the owner's request signals downstream, and returns `ack` and read data to the owner only. An optional watchdog aborts stalled transfers.

## Interface
- `N_MASTERS`, 2: number of requesting masters, 2..8.
- `ADR_W`, 4: address width forwarded to the interconnect.
- `TIMEOUT`, 255: stall limit in cycles, 1..65535. Used only with the watchdog.

- `clk`  in  1  bus clock; all logic on the rising edge.
- `rst`  in  1  asynchronous active-low reset: asserts immediately, deasserts synchronously to `clk`.
- `m_cyc`  in  N_MASTERS  per-master bus request / cycle-in-progress.
- `m_stb`  in  N_MASTERS  per-master strobe.
- `m_we`  in  N_MASTERS  per-master write enable.
- `m_adr`  in  N_MASTERS*ADR_W  packed addresses; master i at bits [i*ADR_W +: ADR_W].
- `m_dat_c`  in  N_MASTERS*32  packed write data; master i at bits [i*32 +: 32].
- `m_dat_p`  out  32  read data, broadcast to all masters; valid only with that master's `m_ack`.
- `m_ack`  out  N_MASTERS  per-master acknowledge.
- `m_err`  out  N_MASTERS  per-master timeout error pulse. Tied 0 without the watchdog.
- `s_cyc`, `s_stb`, `s_we`  out  1  request signals to the interconnect.
- `s_adr`  out  ADR_W  address to the interconnect.
- `s_dat_c`  out  32  write data to the interconnect.
- `s_dat_p`  in  32  read data from the interconnect.
- `s_ack`  in  1  acknowledge from the interconnect.
- `grant`  out  N_MASTERS  one-hot current owner; all zero when idle.

## Operation
- State register `{IDLE, OWNED, FLUSH}`.
- Registers: `owner` index, `last` index, watchdog counter.
- IDLE:
  - If any `m_cyc` is high, pick the first requester scanning from `last+1` upward, wrapping modulo N_MASTERS.
  - Register that master as `owner` and `last`. Next state OWNED.
- OWNED:
  - `s_cyc=m_cyc[owner]`, `s_stb=m_stb[owner]`.
  - `s_we`, `s_adr`, `s_dat_c` come from the owner's slices.
  - `m_ack[owner]=s_ack`; all other `m_ack` bits are 0.
  - `m_dat_p=s_dat_p`.
- Release: when `m_cyc[owner]` is low at a clock edge, go to IDLE and clear `grant`.
  - This applies even if `m_stb[owner]` was high, which is a protocol violation; the bus is released anyway.
- Non-owners' `stb` is ignored. Their requests stay pending until granted; masters must hold `cyc` while waiting.
- Bursts: the owner keeps the bus across any number of `stb`/`ack` beats while `cyc` stays high. No preemption.
- Outside OWNED: `s_cyc=s_stb=0`, all `m_ack=0`. `s_we`, `s_adr`, `s_dat_c` are don't-care, driven from master 0.
- FLUSH: exists only with the watchdog; see Configuration.

## Timing
- Reset values: state IDLE, `grant=0`, `owner=0`, `last=N_MASTERS-1` (so master 0 wins first), watchdog 0.
- All outputs are 0 during reset.
- Arbitration latency: a request seen in IDLE at edge k gives `grant` and `s_cyc` high after edge k. Minimum one cycle from `m_cyc` rising to `s_cyc` rising.
- Handover: the owner drops `cyc` before edge k, so IDLE follows edge k. The next owner is granted after edge k+1. This guarantees one dead cycle with `s_cyc=0` between owners.
- Datapath (request and ack) is combinational through the mux. No added latency once granted.
- Simultaneous requests: strict round-robin from `last+1`.
  - Masters 0 and 1 request continuously → grants alternate 0,1,0,1.
  - A sole requester is re-granted after its own release (one dead cycle between its grants).
- `s_ack` arriving in the same cycle the owner drops `cyc`: the ack is passed through combinationally. A master must not rely on that ack.
- Reset mid-transfer: bus outputs drop to 0 asynchronously. No ack or err is generated.

## Configuration
- Macro `WB_ARBITER_TIMEOUT_EN`.
- Defined:
  - A 16-bit watchdog counts cycles in OWNED with `s_stb=1` and `s_ack=0`. It clears on `s_ack` or `s_stb=0`.
  - When the count reaches `TIMEOUT`:
    - `m_err[owner]` pulses for 1 cycle, with `m_ack[owner]=0` in that cycle.
    - State goes to FLUSH.
  - FLUSH: `s_cyc=s_stb=0` and `s_ack` is ignored. Return to IDLE once `m_cyc[owner]` is low.
- Undefined: no counter, no FLUSH state, `m_err` constant 0. A stalled slave holds the bus indefinitely.

## Test plan
- Reset with `m_cyc=2'b01` held → `s_cyc=0` during reset. After release, `grant=2'b01` and `s_cyc=1` one cycle later.
- Master 1 write to `adr=4'h3`, `dat_c=32'hDEADBEEF`, ack after 2 cycles → `s_adr=3`, `s_we=1`, `m_ack=2'b10` for 1 cycle, `m_ack[0]` stays 0.
- Both masters hold `cyc`, each doing 1 transfer then dropping `cyc` for 1 cycle → grants 0,1,0,1 with exactly 1 idle `s_cyc=0` cycle between owners.
- Master 0 burst of 4 reads while master 1 requests → master 1 is not granted until master 0 drops `cyc`. Master 0 receives `m_dat_p` values 1,2,3,4.
- With `WB_ARBITER_TIMEOUT_EN` and `TIMEOUT=8`, a slave that never acks → `m_err[owner]` pulses at stall cycle 8 and `s_cyc=0` the next cycle. After the owner drops `cyc`, master 1 is granted.
- Async reset asserted mid-burst → `s_cyc`, `s_stb`, `grant` go 0 without waiting for `clk`. After release, arbitration restarts with master 0 highest.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: per-master request side plus the single interconnect side.
// Modport master is the arbiter's view; modport slave is the surrounding system's view.
interface wb_arbiter_if #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADR_W     = 4
);
    logic [N_MASTERS-1:0]       m_cyc;
    logic [N_MASTERS-1:0]       m_stb;
    logic [N_MASTERS-1:0]       m_we;
    logic [N_MASTERS*ADR_W-1:0] m_adr;
    logic [N_MASTERS*32-1:0]    m_dat_c;
    logic [31:0]                m_dat_p;
    logic [N_MASTERS-1:0]       m_ack;
    logic [N_MASTERS-1:0]       m_err;
    logic                       s_cyc;
    logic                       s_stb;
    logic                       s_we;
    logic [ADR_W-1:0]           s_adr;
    logic [31:0]                s_dat_c;
    logic [31:0]                s_dat_p;
    logic                       s_ack;
    logic [N_MASTERS-1:0]       grant;

    modport master (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_c, s_dat_p, s_ack,
        output m_dat_p, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_c, grant
    );

    modport slave (
        output m_cyc, m_stb, m_we, m_adr, m_dat_c, s_dat_p, s_ack,
        input  m_dat_p, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_c, grant
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: one master owns the interconnect for a whole cyc cycle.
// Define WB_ARBITER_TIMEOUT_EN to add the stall watchdog and FLUSH recovery state.
module wb_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADR_W     = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic          clk,
    input logic          rst,
    wb_arbiter_if.master bus
);
    localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

`ifdef WB_ARBITER_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, OWNED, FLUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWNED} state_t;
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    state_t           r_state;
    state_t           w_state_nx;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_owner_nx;
    logic [IDX_W-1:0] w_last_nx;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_sel;
    logic             w_found;
    logic             w_timeout;

    // First requester scanning upward from last+1, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                if (!w_found && bus.m_cyc[i] &&
                    ((int'(r_last) + k) % N_MASTERS) == i) begin
                    w_found = 1'b1;
                    w_pick  = IDX_W'(i);
                end
            end
        end
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    logic [15:0] r_wdog;
    logic        w_stall;

    assign w_stall   = (r_state == OWNED) && bus.m_cyc[r_owner] &&
                       bus.m_stb[r_owner] && !bus.s_ack;
    assign w_timeout = w_stall && (r_wdog == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_wdog <= '0;
        else if (w_stall && !w_timeout)
            r_wdog <= r_wdog + 16'd1;
        else
            r_wdog <= '0;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= IDX_W'(N_MASTERS - 1);
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nx = OWNED;
                    w_owner_nx = w_pick;
                    w_last_nx  = w_pick;
                end
            end
            OWNED: begin
                if (!bus.m_cyc[r_owner])
                    w_state_nx = IDLE;
`ifdef WB_ARBITER_TIMEOUT_EN
                else if (w_timeout)
                    w_state_nx = FLUSH;
            end
            FLUSH: begin
                if (!bus.m_cyc[r_owner])
                    w_state_nx = IDLE;
`endif
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Datapath mux; outside OWNED the don't-care bus fields follow master 0.
    always_comb begin
        w_sel       = (r_state == OWNED) ? r_owner : '0;
        bus.s_cyc   = 1'b0;
        bus.s_stb   = 1'b0;
        bus.s_we    = 1'b0;
        bus.s_adr   = '0;
        bus.s_dat_c = '0;
        bus.m_ack   = '0;
        bus.m_err   = '0;
        bus.grant   = '0;
        bus.m_dat_p = bus.s_dat_p;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (w_sel == IDX_W'(i)) begin
                bus.s_we    = bus.m_we[i];
                bus.s_adr   = bus.m_adr[i*ADR_W +: ADR_W];
                bus.s_dat_c = bus.m_dat_c[i*32 +: 32];
            end
        end
        if (r_state == OWNED) begin
            bus.s_cyc          = bus.m_cyc[r_owner];
            bus.s_stb          = bus.m_stb[r_owner];
            bus.grant[r_owner] = 1'b1;
            bus.m_ack[r_owner] = bus.s_ack && !w_timeout;
            bus.m_err[r_owner] = w_timeout;
        end
`ifdef WB_ARBITER_TIMEOUT_EN
        if (r_state == FLUSH)
            bus.grant[r_owner] = 1'b1;
`endif
        if (!rst) begin
            bus.s_we    = 1'b0;
            bus.s_adr   = '0;
            bus.s_dat_c = '0;
            bus.m_dat_p = '0;
        end
    end
endmodule
